// File: rtl/cpu_pkg.sv
// Shared ISA constants for the conditional-execution path: condition codes,
// NZCV bit positions and the long-op writeback FSM encoding.
package cpu_pkg;

  localparam int unsigned COND_W  = 4;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned STATE_W = 1;

  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_CS = 4'b0010;
  localparam logic [COND_W-1:0] COND_CC = 4'b0011;
  localparam logic [COND_W-1:0] COND_MI = 4'b0100;
  localparam logic [COND_W-1:0] COND_PL = 4'b0101;
  localparam logic [COND_W-1:0] COND_VS = 4'b0110;
  localparam logic [COND_W-1:0] COND_VC = 4'b0111;
  localparam logic [COND_W-1:0] COND_HI = 4'b1000;
  localparam logic [COND_W-1:0] COND_LS = 4'b1001;
  localparam logic [COND_W-1:0] COND_GE = 4'b1010;
  localparam logic [COND_W-1:0] COND_LT = 4'b1011;
  localparam logic [COND_W-1:0] COND_GT = 4'b1100;
  localparam logic [COND_W-1:0] COND_LE = 4'b1101;
  localparam logic [COND_W-1:0] COND_AL = 4'b1110;
  localparam logic [COND_W-1:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 1'b0,
    ST_LONG_HI = 1'b1
  } state_e;

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code evaluator: decides whether an instruction's
// condition field passes against the stored NZCV flags.
module cond_check
  import cpu_pkg::*;
(
  input  logic [COND_W-1:0]  i_cond,
  input  logic [FLAGS_W-1:0] i_flags,
  output logic               o_pass
);

  logic w_n, w_z, w_c, w_v;
  logic w_ge;

  assign w_n  = i_flags[FLAG_N];
  assign w_z  = i_flags[FLAG_Z];
  assign w_c  = i_flags[FLAG_C];
  assign w_v  = i_flags[FLAG_V];
  assign w_ge = (w_n == w_v);

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = ~w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = ~w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = ~w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = ~w_v;
      COND_HI: o_pass = w_c & ~w_z;
      COND_LS: o_pass = ~w_c | w_z;
      COND_GE: o_pass = w_ge;
      COND_LT: o_pass = ~w_ge;
      COND_GT: o_pass = ~w_z & w_ge;
      COND_LE: o_pass = w_z | ~w_ge;
      COND_AL: o_pass = 1'b1;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: NZCV flag register, strobe gating and the
// two-cycle RdLo/RdHi writeback sequencer for 64-bit multiplies.
module cond_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               Valid,
  input  logic [COND_W-1:0]  Cond,
  input  logic [FLAGS_W-1:0] ALUFlags,
  input  logic [1:0]         FlagW,
  input  logic               PCS,
  input  logic               RegW,
  input  logic               MemW,
  input  logic               NoWrite,
  input  logic               LongOp,
  output logic               CondEx,
  output logic               PCSrc,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               WriteSel,
  output logic               Stall,
  output logic [FLAGS_W-1:0] Flags
);

  state_e             r_state;
  state_e             w_next_state;
  logic [FLAGS_W-1:0] r_flags;
  logic               w_pass;
  logic               w_valid;
  logic               w_condex_idle;
  logic               w_reg_req;
  logic               w_long_start;

  cond_check u_cond_check (
    .i_cond  (Cond),
    .i_flags (r_flags),
    .o_pass  (w_pass)
  );

  // Valid is masked by reset so every strobe reads 0 while reset is held.
  assign w_valid       = Valid & reset;
  assign w_condex_idle = w_valid & w_pass;
  assign w_reg_req     = RegW & ~NoWrite;
  assign w_long_start  = w_condex_idle & LongOp & w_reg_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_long_start) w_next_state = ST_LONG_HI;
      ST_LONG_HI: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    CondEx   = 1'b0;
    PCSrc    = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    WriteSel = 1'b0;
    Stall    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        CondEx   = w_condex_idle;
        PCSrc    = w_condex_idle & PCS;
        MemWrite = w_condex_idle & MemW;
        RegWrite = w_condex_idle & w_reg_req;
        Stall    = w_long_start;
      end
      // Second half of a long op: upstream still holds it, so write RdHi.
      ST_LONG_HI: begin
        CondEx   = 1'b1;
        RegWrite = 1'b1;
        WriteSel = 1'b1;
      end
      default: ;
    endcase
  end

  // Flags only update from an executing instruction in IDLE; no forwarding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= '0;
    end else if ((r_state == ST_IDLE) && w_condex_idle) begin
      if (FlagW[1]) begin
        r_flags[FLAG_N] <= ALUFlags[FLAG_N];
        r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (FlagW[0]) begin
        r_flags[FLAG_C] <= ALUFlags[FLAG_C];
        r_flags[FLAG_V] <= ALUFlags[FLAG_V];
      end
    end
  end

  assign Flags = r_flags;

endmodule

// File: tb/tb_cond_unit.sv
// Directed-vector bench for cond_unit with hand-computed expectations.
module tb_cond_unit;

  logic       clk;
  logic       reset;
  logic       Valid;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite, LongOp;
  logic       CondEx, PCSrc, RegWrite, MemWrite, WriteSel, Stall;
  logic [3:0] Flags;

  int n_checks = 0;
  int n_errors = 0;

  cond_unit dut (
    .clk      (clk),
    .reset    (reset),
    .Valid    (Valid),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .LongOp   (LongOp),
    .CondEx   (CondEx),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .WriteSel (WriteSel),
    .Stall    (Stall),
    .Flags    (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] af,
                       input logic [1:0] fw, input logic pcs, input logic rw,
                       input logic mw, input logic nw, input logic lo);
    Valid = v; Cond = c; ALUFlags = af; FlagW = fw;
    PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw; LongOp = lo;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs {CondEx,PCSrc,RegWrite,MemWrite,WriteSel,Stall} for compact checks.
  function automatic logic [7:0] strobes();
    return {2'b00, CondEx, PCSrc, RegWrite, MemWrite, WriteSel, Stall};
  endfunction

  initial begin
    reset = 1'b0;
    drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #12;
    check("reset_strobes", strobes(), 8'h00);
    check("reset_flags", 8'(Flags), 8'h00);

    reset = 1'b1;
    tick();
    // EQ with stored Z=0 fails
    drive(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("eq_z0", strobes(), 8'h00);
    tick();
    // AL sets NZCV=0100
    drive(1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("al_set", strobes(), 8'b0010_1000);
    check("flag_latency", 8'(Flags), 8'h00);
    tick();
    check("flags_0100", 8'(Flags), 8'h04);
    // EQ now passes; also clears flags against old Z=1
    drive(1'b1, 4'b0000, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("eq_z1", strobes(), 8'b0010_1000);
    tick();
    check("flags_self_old", 8'(Flags), 8'h00);
    drive(1'b1, 4'b1110, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("flags_1001", 8'(Flags), 8'h09);

    drive(1'b1, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ge", 8'(CondEx), 8'h01);
    drive(1'b1, 4'b1011, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lt", 8'(CondEx), 8'h00);
    drive(1'b1, 4'b1100, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("gt", 8'(CondEx), 8'h01);
    drive(1'b1, 4'b1000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("hi", 8'(CondEx), 8'h00);
    drive(1'b1, 4'b1001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ls", 8'(CondEx), 8'h01);
    drive(1'b1, 4'b1111, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("nv_strobes", strobes(), 8'h00);
    drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("nowrite", strobes(), 8'b0011_0100);
    drive(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("invalid", strobes(), 8'h00);
    tick();
    check("nv_no_flag", 8'(Flags), 8'h09);

    drive(1'b1, 4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b1110, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("flagw_nz_only", 8'(Flags), 8'h0C);

    // Long op: IDLE cycle writes RdLo and stalls
    drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("long_c0", strobes(), 8'b0011_1101);
    tick();
    drive(1'b0, 4'b1111, 4'b0011, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("long_c1", strobes(), 8'b0010_1010);
    tick();
    check("long_no_flag", 8'(Flags), 8'h0C);
    drive(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("long_c2_idle", strobes(), 8'h00);

    // Back-to-back long ops with no bubble
    drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("b2b_stall", 8'(Stall), 8'((i % 2) == 0));
      check("b2b_wsel", 8'(WriteSel), 8'((i % 2) == 1));
      tick();
    end

    // Long op failing its condition (Z=1, NE) is a no-op
    drive(1'b1, 4'b0001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("long_fail", strobes(), 8'h00);
    tick();
    drive(1'b0, 4'b0001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("long_fail_idle", strobes(), 8'h00);

    // Async reset during LONG_HI
    drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check("pre_rst_hi", 8'(WriteSel), 8'h01);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_strobes", strobes(), 8'h00);
    check("rst_mid_flags", 8'(Flags), 8'h00);
    #3;
    reset = 1'b1;
    drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_rst_idle", strobes(), 8'b0010_1000);
    tick();
    check("post_rst_stay", strobes(), 8'b0010_1000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution unit for the processor datapath, sitting directly downstream of the ALU. It holds the architectural NZCV flag register and captures the ALU's `ALUFlags` under per-group write enables. It evaluates each instruction's 4-bit condition field against the stored flags and gates the register-write, memory-write and PC-source strobes. It also sequences the two-cycle register writeback required by the 64-bit long-multiply ops (SMUL/UMUL), whose high word arrives on the ALU's `Long` output.

## Interface
- No parameters; all widths fixed by the ISA.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately when low.
- `Valid` in 1: an instruction is presented in this cycle.
- `Cond` in 4: instruction condition field.
- `ALUFlags` in 4: {N,Z,C,V} from the ALU for the current instruction.
- `FlagW` in 2: [1] requests an N,Z update; [0] requests a C,V update.
- `PCS`, `RegW`, `MemW` in 1 each: decoder requests for PC write, register write and memory write.
- `NoWrite` in 1: compare-type op; suppresses the register write.
- `LongOp` in 1: the instruction is SMUL or UMUL (64-bit result).
- `CondEx` out 1: the condition passed and the instruction executes.
- `PCSrc`, `RegWrite`, `MemWrite` out 1 each: gated strobes.
- `WriteSel` out 1: 0 selects the ALU `Result` onto the RdLo port; 1 selects the ALU `Long` onto the RdHi port.
- `Stall` out 1: upstream must hold the instruction and operands for one more cycle.
- `Flags` out 4: stored {N,Z,C,V}.

## Operation
- Flag register:
  - N,Z load `ALUFlags[3:2]` when `Valid & CondEx & FlagW[1]` in state IDLE.
  - C,V load `ALUFlags[1:0]` when `Valid & CondEx & FlagW[0]` in state IDLE.
  - No flag update occurs in state LONG_HI.
- The condition is evaluated against the stored `Flags` only, never against `ALUFlags`. Codes:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111: 0 (reserved; the instruction is suppressed).
- `CondEx` = `Valid & cond_pass`.
- Strobes in IDLE:
  - `PCSrc` = `CondEx & PCS`.
  - `MemWrite` = `CondEx & MemW`.
  - `RegWrite` = `CondEx & RegW & !NoWrite`.
- FSM states IDLE and LONG_HI; reset state is IDLE.
  - IDLE → LONG_HI when `CondEx & LongOp & RegW & !NoWrite`. In that cycle: `RegWrite`=1, `WriteSel`=0, `Stall`=1.
  - LONG_HI → IDLE unconditionally. In that cycle: `RegWrite`=1, `WriteSel`=1, `Stall`=0, `PCSrc`=0, `MemWrite`=0, `CondEx`=1.
  - In LONG_HI, `Valid`, `Cond` and `FlagW` are ignored. Upstream holds the same instruction, so the `Long` output is still stable.
- A long op that fails its condition behaves as a no-op: it stays in IDLE and does not stall.
- Reset asserted mid-sequence: state returns to IDLE and the pending RdHi write is lost.

## Timing
- Reset values:
  - `Flags`=0000, state=IDLE.
  - Every output reads 0 while `reset` is low. `CondEx` reads 0 because `Valid` is gated.
- Strobes and `CondEx` are combinational from the stored state plus the inputs, with zero latency, valid in the same cycle as `Valid`.
- Flag updates are visible to the next instruction: one-cycle latency, with no forwarding.
- A flag-setting instruction evaluates its own condition against the old flags.
- A long op occupies exactly 2 cycles, and `Stall` is high for exactly the first of them.
- Back-to-back long ops follow the pattern IDLE, LONG_HI, IDLE, LONG_HI with no bubble.

## Structure
- Shared package `cpu_pkg`:
  - condition-code localparams (`COND_EQ` … `COND_AL`, `COND_NV`);
  - the flag bit indices N=3, Z=2, C=1, V=0;
  - the FSM state encoding.
- One sub-module, `cond_check`: purely combinational, taking `Cond` and `Flags` and producing `cond_pass`.
- `cond_unit` holds the flag register, the FSM and the strobe gating.

## Test plan
- Reset, then `Valid`=1, `Cond`=0000, `RegW`=1. Expect `CondEx`=0, because stored Z=0. Set the flags with `FlagW`=11 and `ALUFlags`=0100. On the next cycle, `Cond`=0000 gives `CondEx`=1 and `RegWrite`=1.
- Stored `Flags`=1001, i.e. N=V. Expect:
  - `Cond`=1010 (GE) → `CondEx`=1.
  - `Cond`=1011 (LT) → 0.
  - `Cond`=1100 (GT) → 1.
  - `Cond`=1111 → 0, with all strobes 0.
- `FlagW`=10 with `ALUFlags`=1111 from stored 0000 → `Flags`=1100 on the next cycle; C,V are unchanged.
- `LongOp`=1, `RegW`=1, `Cond`=1110. Expect:
  - cycle 0: `RegWrite`=1, `WriteSel`=0, `Stall`=1;
  - cycle 1: `RegWrite`=1, `WriteSel`=1, `Stall`=0, with the `FlagW`=11 input ignored;
  - cycle 2: back in IDLE.
- Long op with `Cond`=0000 and Z=0 → no stall, `RegWrite`=0, state stays IDLE.
- Drive `reset` low asynchronously during LONG_HI → `RegWrite`, `Stall` and `Flags` drop to 0 immediately. After release, the next instruction starts in IDLE.
